keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV_BITS, default 17, sets column dwell to 2^SCAN_DIV_BITS clock cycles.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, sets the number of consecutive full scans needed to accept a press or a release (legal range 1..15).
REQ-003 clock  input  1  system clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 row  input  4  keypad row lines; active-low, asynchronous to clock, pulled high when no key is pressed.
REQ-006 col  output  4  keypad column drive; active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  code of the accepted key, equal to row_index*4 + col_index.
REQ-008 key_valid  output  1  one-cycle pulse marking a newly accepted press.
REQ-009 key_held  output  1  high from acceptance of a press until acceptance of its release.

Function
REQ-010 Row inputs SHALL pass through a 2-flop synchronizer before any use.
REQ-011 A free-running SCAN_DIV_BITS-bit prescaler SHALL generate tick whenever it equals all-ones; the prescaler then wraps to 0.
REQ-012 A 2-bit col_idx SHALL advance 0->1->2->3->0 on each tick; col = ~(4'b0001 << col_idx).
REQ-013 On each tick, the synchronized row value for the current col_idx SHALL be captured before col_idx advances.
REQ-014 On a tick with col_idx==3 (scan end), scan_result SHALL be computed over the 4 captures as follows.
- Exactly one low row bit in exactly one column: valid, with that code.
- No low bit: none.
- More than one low bit in total (ghost or multi-press): none.
REQ-015 The debounce FSM SHALL have states IDLE, CAND, PRESSED and RELEASING, and SHALL evaluate only at scan end.
REQ-016 IDLE: on a valid result, store cand=code, set cnt=1 and go to CAND; if DEBOUNCE_SCANS==1, go directly to PRESSED with the accept actions.
REQ-017 CAND: on a result equal to cand, increment cnt; when cnt reaches DEBOUNCE_SCANS, go to PRESSED.
REQ-018 CAND: on a valid result different from cand, reload cand, set cnt=1 and stay in CAND; on a none result, go to IDLE.
REQ-019 Entry to PRESSED SHALL, in the cycle after scan end, load key_code=cand, pulse key_valid for exactly 1 cycle, and set key_held=1.
REQ-020 PRESSED: on any result not equal to cand, set cnt=1 and go to RELEASING; on a result equal to cand, stay in PRESSED.
REQ-021 RELEASING: on a result equal to cand, return to PRESSED without a new key_valid.
REQ-022 RELEASING: on any other result, increment cnt; at DEBOUNCE_SCANS, go to IDLE and clear key_held.
REQ-023 key_code SHALL hold its last accepted value until the next acceptance.
REQ-024 A different key pressed while PRESSED is not accepted until the original key is released and the new key is then debounced from IDLE.
REQ-025 Press-to-key_valid latency SHALL be DEBOUNCE_SCANS full scans (up to one extra scan of alignment) plus 3 cycles (2 synchronizer cycles + 1 output register cycle).
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While reset is high, the following SHALL hold at the next edge: prescaler=0, col_idx=0, col=4'b1110, captures=4'b1111, FSM=IDLE, cnt=0, cand=0, key_code=0, key_valid=0, key_held=0, synchronizers=4'b1111.
REQ-028 Reset asserted mid-debounce or while PRESSED SHALL abort without emitting key_valid; after reset is released, scanning restarts at column 0 with no partial-scan carry-over.

Structure
REQ-029 Package keypad_pkg SHALL hold the FSM state enum, NUM_ROWS=4, NUM_COLS=4 and the code width of 4.
REQ-030 Sub-module keypad_debounce SHALL contain the FSM, cnt and cand, taking scan_end, result_valid and result_code as inputs; the scan, prescaler and capture logic stay in the top module.

Verification (SCAN_DIV_BITS=2, DEBOUNCE_SCANS=3; dwell 4 cycles, scan 16 cycles)
REQ-031 Reset, then no key for 10 scans -> col cycles 1110, 1101, 1011, 0111 every 4 cycles; key_valid never pulses; key_held=0.
REQ-032 Hold row[2] low whenever col[1] is low, for 6 scans -> one key_valid pulse with key_code=9, after the 3rd full matching scan; key_held=1.
REQ-033 Release, with 1 scan bouncing back to key 9 in between -> key_held stays 1; after 3 further consecutive non-9 scans, key_held=0; no second key_valid.
REQ-034 Press key 0 and key 5 simultaneously -> results are none; no key_valid pulse.
REQ-035 Key 3 stable for 2 scans, then key 7 stable for 3 scans -> exactly one key_valid pulse with key_code=7.
REQ-036 Assert reset during the 2nd debounce scan of key 9 -> no key_valid; col=1110 the cycle after reset; a clean press then takes 3 full scans to accept.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and sizes for the 4x4 keypad scanner.
//   NUM_ROWS / NUM_COLS : keypad matrix dimensions
//   CODE_W              : width of a key code (row_index*4 + col_index)
//   deb_state_t         : debounce FSM states
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAND,
    S_PRESSED,
    S_RELEASING
  } deb_state_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundle between the keypad matrix and the scanner.
//   row       : active-low row sense lines (keypad -> scanner)
//   col       : active-low column drive (scanner -> keypad)
//   key_code  : last accepted key code
//   key_valid : one-cycle pulse on a newly accepted press
//   key_held  : high from press acceptance until release acceptance
// slave  = scanner side, master = keypad/environment side.
// -----------------------------------------------------------------------------
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  logic [CODE_W-1:0]   key_code;
  logic                key_valid;
  logic                key_held;

  modport slave  (input  row, output col, key_code, key_valid, key_held);
  modport master (output row, input  col, key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Press/release debounce FSM, evaluated once per full scan.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_scan_end       : one-cycle strobe at the last column tick of a scan
//   i_result_valid   : scan saw exactly one pressed key
//   i_result_code    : code of that key
//   o_key_code       : last accepted key code (held until next acceptance)
//   o_key_valid      : one-cycle pulse on acceptance of a press
//   o_key_held       : high between press acceptance and release acceptance
// -----------------------------------------------------------------------------
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_scan_end,
  input  logic              i_result_valid,
  input  logic [CODE_W-1:0] i_result_code,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_valid,
  output logic              o_key_held
);

  localparam logic [3:0] N_SCANS = 4'(DEBOUNCE_SCANS);

  deb_state_t        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [CODE_W-1:0] r_cand, w_cand_nxt;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid, r_key_held;
  logic              w_accept, w_release, w_match;
  logic [3:0]        w_cnt_inc;

  assign w_match   = i_result_valid && (i_result_code == r_cand);
  assign w_cnt_inc = r_cnt + 4'd1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    if (i_scan_end) begin
      unique case (r_state)
        S_IDLE: if (i_result_valid) begin
          w_cand_nxt = i_result_code;
          w_cnt_nxt  = 4'd1;
          if (N_SCANS == 4'd1) begin
            w_state_nxt = S_PRESSED;
            w_accept    = 1'b1;
          end else begin
            w_state_nxt = S_CAND;
          end
        end
        S_CAND: begin
          if (w_match) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= N_SCANS) begin
              w_state_nxt = S_PRESSED;
              w_accept    = 1'b1;
            end
          end else if (i_result_valid) begin
            w_cand_nxt = i_result_code;
            w_cnt_nxt  = 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESSED: if (!w_match) begin
          w_cnt_nxt = 4'd1;
          // With a single-scan debounce this first miss is already the release.
          if (N_SCANS == 4'd1) begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
          end else begin
            w_state_nxt = S_RELEASING;
          end
        end
        S_RELEASING: begin
          if (w_match) begin
            w_state_nxt = S_PRESSED;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= N_SCANS) begin
              w_state_nxt = S_IDLE;
              w_release   = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand      <= w_cand_nxt;
      r_key_valid <= w_accept;
      if (w_accept)       r_key_code <= w_cand_nxt;
      if (w_accept)       r_key_held <= 1'b1;
      else if (w_release) r_key_held <= 1'b0;
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = r_key_held;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 matrix keypad scanner: drives one column low at a time, samples the
// synchronized rows at the end of each column dwell, classifies each full scan
// and hands the result to the debounce FSM.
//   i_clock, i_reset : clock, synchronous active-high reset
//   kp (slave)       : row in; col, key_code, key_valid, key_held out
// Parameters: SCAN_DIV_BITS (dwell = 2^SCAN_DIV_BITS cycles),
//             DEBOUNCE_SCANS (scans to accept a press/release, 1..15).
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  keypad_scanner_if.slave  kp
);

  logic [NUM_ROWS-1:0]      r_row_s1, r_row_s2;
  logic [SCAN_DIV_BITS-1:0] r_presc;
  logic [1:0]               r_col_idx, w_col_idx_nxt;
  logic [NUM_COLS-1:0]      r_col;
  logic [NUM_ROWS-1:0]      r_cap [NUM_COLS];
  logic [NUM_ROWS-1:0]      w_cap [NUM_COLS];
  logic                     w_tick, w_scan_end, w_result_valid;
  logic [4:0]               w_low_cnt;
  logic [CODE_W-1:0]        w_code;

  assign w_tick        = &r_presc;
  assign w_scan_end    = w_tick && (r_col_idx == 2'd3);
  assign w_col_idx_nxt = r_col_idx + 2'd1;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_row_s1  <= '1;
      r_row_s2  <= '1;
      r_presc   <= '0;
      r_col_idx <= '0;
      r_col     <= 4'b1110;
      // NOTE: the capture array is reset (it is only four nibbles) so a scan
      // interrupted by reset can never leak stale presses into the next one.
      for (int c = 0; c < NUM_COLS; c++) r_cap[c] <= '1;
    end else begin
      r_row_s1 <= kp.row;
      r_row_s2 <= r_row_s1;
      r_presc  <= r_presc + SCAN_DIV_BITS'(1);
      if (w_tick) begin
        r_cap[r_col_idx] <= r_row_s2;
        r_col_idx        <= w_col_idx_nxt;
        r_col            <= ~(4'b0001 << w_col_idx_nxt);
      end
    end
  end

  // The last column is captured on the same edge the scan is evaluated, so
  // its fresh sample is forwarded instead of the stored one.
  always_comb begin
    for (int c = 0; c < NUM_COLS; c++)
      w_cap[c] = (w_tick && (2'(c) == r_col_idx)) ? r_row_s2 : r_cap[c];
  end

  // Count low row bits over the whole scan; one low bit gives a key, zero or
  // several (multi-press / ghosting) give no result.
  always_comb begin
    w_low_cnt = '0;
    w_code    = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (!w_cap[c][r]) begin
          w_low_cnt = w_low_cnt + 5'd1;
          w_code    = CODE_W'(r * NUM_COLS + c);
        end
      end
    end
  end

  assign w_result_valid = (w_low_cnt == 5'd1);

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_scan_end     (w_scan_end),
    .i_result_valid (w_result_valid),
    .i_result_code  (w_code),
    .o_key_code     (kp.key_code),
    .o_key_valid    (kp.key_valid),
    .o_key_held     (kp.key_held)
  );

  assign kp.col = r_col;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with a 4-cycle dwell (16-cycle scan) and a
// 3-scan debounce. A combinational keypad model pulls a row low whenever a
// pressed key's column is driven low. Cycle numbers count clock edges since
// the last reset release; scan k occupies cycles 16k .. 16k+15.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV_BITS  (2),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .i_clock (clk),
    .i_reset (reset),
    .kp      (kp)
  );

  // Bit index = row*4 + col, i.e. the key code.
  logic [15:0] pressed = '0;

  always_comb begin
    kp.row = '1;
    for (int r = 0; r < NUM_ROWS; r++)
      kp.row[r] = ~|(pressed[r*4 +: 4] & ~kp.col);
  end

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_valid = 0;
  int col_bad = 0;
  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) n_valid++;
    if (!reset && !$onehot(~kp.col)) col_bad++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the falling edge inside cycle k; cyc only grows, so this ends.
  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  int nv_before;

  initial begin
    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst_col",   kp.col, 4'b1110);
    check("rst_valid", kp.key_valid, 1'b0);
    check("rst_held",  kp.key_held, 1'b0);
    check("rst_code",  kp.key_code, 4'd0);
    reset = 1'b0;

    // ---- idle scanning: column walk every 4 cycles
    check("col_c0",  kp.col, 4'b1110);
    wait_cyc(3);  check("col_c3",  kp.col, 4'b1110);
    wait_cyc(4);  check("col_c4",  kp.col, 4'b1101);
    wait_cyc(8);  check("col_c8",  kp.col, 4'b1011);
    wait_cyc(12); check("col_c12", kp.col, 4'b0111);
    wait_cyc(16); check("col_c16", kp.col, 4'b1110);
    wait_cyc(160);
    check("idle_nvalid", n_valid, 0);
    check("idle_held",   kp.key_held, 1'b0);

    // ---- key 9 (row 2, col 1) held 6 scans, accepted after 3rd scan end (P207)
    pressed = 16'h0200;
    wait_cyc(207);
    check("k9_pre_valid", kp.key_valid, 1'b0);
    check("k9_pre_n",     n_valid, 0);
    wait_cyc(208);
    check("k9_valid", kp.key_valid, 1'b1);
    check("k9_code",  kp.key_code, 4'd9);
    check("k9_held",  kp.key_held, 1'b1);
    wait_cyc(209);
    check("k9_pulse_1cyc", kp.key_valid, 1'b0);
    wait_cyc(256);
    check("k9_once", n_valid, 1);
    check("k9_held_still", kp.key_held, 1'b1);

    // ---- release with one bounce scan back to 9
    pressed = '0;
    wait_cyc(272); pressed = 16'h0200;
    wait_cyc(288); pressed = '0;
    wait_cyc(300); check("rel_bounce_held", kp.key_held, 1'b1);
    wait_cyc(335); check("rel_pre_held",    kp.key_held, 1'b1);
    wait_cyc(336);
    check("rel_held_clr", kp.key_held, 1'b0);
    check("rel_no_valid", n_valid, 1);

    // ---- keys 0 and 5 together: rejected
    pressed = 16'h0021;
    wait_cyc(432);
    check("multi_nvalid", n_valid, 1);
    check("multi_held",   kp.key_held, 1'b0);
    check("code_kept",    kp.key_code, 4'd9);

    // ---- key 3 for 2 scans, then key 7 for 3 scans
    pressed = 16'h0008;
    wait_cyc(464); pressed = 16'h0080;
    wait_cyc(511); check("k7_pre_n", n_valid, 1);
    wait_cyc(512);
    check("k7_valid", kp.key_valid, 1'b1);
    check("k7_code",  kp.key_code, 4'd7);
    wait_cyc(528);
    check("k7_once", n_valid, 2);
    check("k7_held", kp.key_held, 1'b1);
    pressed = '0;
    wait_cyc(576); check("k7_released", kp.key_held, 1'b0);

    // ---- reset during second debounce scan of key 9
    pressed = 16'h0200;
    wait_cyc(615);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_col",   kp.col, 4'b1110);
    check("mid_rst_code",  kp.key_code, 4'd0);
    check("mid_rst_valid", kp.key_valid, 1'b0);
    reset = 1'b0;
    nv_before = n_valid;
    check("post_rst_col", kp.col, 4'b1110);
    check("post_rst_n",   nv_before, 2);
    wait_cyc(47);
    check("re_pre_valid", kp.key_valid, 1'b0);
    check("re_pre_n",     n_valid, nv_before);
    wait_cyc(48);
    check("re_valid", kp.key_valid, 1'b1);
    check("re_code",  kp.key_code, 4'd9);
    check("re_held",  kp.key_held, 1'b1);
    wait_cyc(49);
    check("re_once", n_valid, nv_before + 1);

    check("col_onehot_low", col_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
